burst_bit_source: RTL

Upstream symbol source for the GMSK transmit path. Buffers one 116-bit normal-burst payload loaded serially, then, on a fire request, streams a 156-symbol burst to the modulator's `current_symbol` input, one symbol per modulator `next_symbol_strobe`. The burst is 3 tail, 58 data, 26 training, 58 data, 3 tail and 8 guard symbols, with optional differential encoding. It replaces the free-running bit source ahead of the modulator and modulator-control stages.

---
 rtl/burst_bit_source.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/burst_bit_source.sv
// Normal-burst symbol source: buffers a 116-bit payload, then streams tail/data/training/guard symbols per modulator strobe.
// Optional differential encoding of tail, data and training symbols when BURST_DIFF_ENCODE_EN is defined.
`timescale 1ns/1ps
module burst_bit_source #(
  parameter logic [25:0] TSC        = 26'b00100101110000100010010111,
  parameter int unsigned GUARD_BITS = 8
) (
  input  logic xtal,
  input  logic reset_n,
  input  logic load_valid,
  input  logic load_bit,
  output logic load_ready,
  input  logic fire,
  input  logic symbol_strobe,
  output logic current_symbol,
  output logic loaded,
  output logic burst_active,
  output logic burst_done
);

  typedef enum logic [2:0] {
    IDLE,
    LOADED,
    TAIL_A,
    DATA_A,
    TRAIN,
    DATA_B,
    TAIL_B,
    GUARD
  } state_t;

  localparam int unsigned PAYLOAD_BITS = 116;

  state_t                  state_q;
  logic [6:0]              loadCnt_q;
  logic [5:0]              secCnt_q;
  logic [PAYLOAD_BITS-1:0] buffer_q;
`ifdef BURST_DIFF_ENCODE_EN
  logic                    hist_q;
`endif

  logic [5:0] secLast;
  logic [6:0] dataIdx;
  logic [4:0] tscIdx;
  logic       rawBit;
  logic       symbol_d;

  assign load_ready = (state_q == IDLE);

  // Raw bit and final counter value for whichever section is being sent.
  always_comb begin
    secLast = 6'd0;
    rawBit  = 1'b0;
    dataIdx = {1'b0, secCnt_q};
    tscIdx  = 5'd25 - secCnt_q[4:0];
    case (state_q)
      TAIL_A, TAIL_B: secLast = 6'd2;
      DATA_A: begin
        secLast = 6'd57;
        rawBit  = buffer_q[dataIdx];
      end
      TRAIN: begin
        secLast = 6'd25;
        rawBit  = TSC[tscIdx];
      end
      DATA_B: begin
        secLast = 6'd57;
        dataIdx = 7'd58 + {1'b0, secCnt_q};
        rawBit  = buffer_q[dataIdx];
      end
      GUARD:   secLast = 6'(GUARD_BITS - 1);
      default: secLast = 6'd0;
    endcase
  end

  always_comb begin
`ifdef BURST_DIFF_ENCODE_EN
    symbol_d = (state_q == GUARD) ? 1'b1 : (rawBit ^ hist_q);
`else
    symbol_d = (state_q == GUARD) ? 1'b1 : rawBit;
`endif
  end

  // The payload store needs no reset; its contents are only read after a full load.
  always_ff @(posedge xtal) begin
    if (load_ready && load_valid) begin
      buffer_q[loadCnt_q] <= load_bit;
    end
  end

  always_ff @(posedge xtal or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      loadCnt_q      <= 7'd0;
      secCnt_q       <= 6'd0;
      current_symbol <= 1'b1;
      loaded         <= 1'b0;
      burst_active   <= 1'b0;
      burst_done     <= 1'b0;
`ifdef BURST_DIFF_ENCODE_EN
      hist_q         <= 1'b1;
`endif
    end else begin
      burst_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            loadCnt_q <= loadCnt_q + 7'd1;
            if (loadCnt_q == 7'd115) begin
              state_q <= LOADED;
              loaded  <= 1'b1;
            end
          end
        end
        LOADED: begin
          if (fire) begin
            state_q      <= TAIL_A;
            secCnt_q     <= 6'd0;
            loaded       <= 1'b0;
            burst_active <= 1'b1;
`ifdef BURST_DIFF_ENCODE_EN
            hist_q       <= 1'b1;
`endif
          end
        end
        default: begin
          if (symbol_strobe) begin
            current_symbol <= symbol_d;
`ifdef BURST_DIFF_ENCODE_EN
            hist_q         <= rawBit;
`endif
            if (secCnt_q == secLast) begin
              secCnt_q <= 6'd0;
              case (state_q)
                TAIL_A: state_q <= DATA_A;
                DATA_A: state_q <= TRAIN;
                TRAIN:  state_q <= DATA_B;
                DATA_B: state_q <= TAIL_B;
                TAIL_B: state_q <= GUARD;
                default: begin
                  state_q      <= IDLE;
                  loadCnt_q    <= 7'd0;
                  burst_active <= 1'b0;
                  burst_done   <= 1'b1;
                end
              endcase
            end else begin
              secCnt_q <= secCnt_q + 6'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
